lshift2_mux32_2to1: RTL and testbench
=====================================

Name: lshift2_mux32_2to1

Overview:
- Branch-target datapath slice of the single-cycle PC logic.
- Left-shifts a 32-bit sign-extended immediate by 2 (word offset to byte offset) and adds it to the current PC.
- A 32-bit 2:1 mux selects either PC or the branch target, using select = Branch & Zero.
- Outputs the combinational mux result and a registered next-PC value (mux result + 4) for the PC register stage.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHIFT, 2, left-shift amount applied to Immed.
- INCR, 4, constant added to the mux result to form NextPC.

Ports:
- Clock  input  1  single clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- PC  input  WIDTH  current program counter.
- Immed  input  WIDTH  sign-extended branch immediate, in words, two's complement.
- Branch  input  1  decoded branch instruction flag.
- Zero  input  1  ALU zero flag.
- ShiftOut  output  WIDTH  Immed << SHIFT, combinational.
- BranchTarget  output  WIDTH  PC + ShiftOut, combinational.
- BranchSelect  output  1  Branch & Zero, combinational.
- MuxOut  output  WIDTH  BranchSelect ? BranchTarget : PC, combinational.
- NextPC  output  WIDTH  registered MuxOut + INCR.
- NextValid  output  1  registered; high from the first cycle after Reset deasserts.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- ShiftOut:
  - Bits [WIDTH-1:SHIFT] = Immed[WIDTH-1-SHIFT:0]; low SHIFT bits = 0.
  - The top SHIFT bits of Immed are discarded. No sign handling beyond that; a negative offset stays negative when Immed[31:29] are all equal.
- BranchTarget: unsigned WIDTH-bit add, wraps modulo 2^WIDTH, no carry out.
- BranchSelect: exactly Branch AND Zero. Branch=1 with Zero=0, or Branch=0 with Zero=1, selects PC.
- MuxOut:
  - sel=0 passes PC, sel=1 passes BranchTarget.
  - Purely combinational, zero latency, no X propagation from the unselected input.
- NextPC:
  - On each rising Clock edge with Reset=0, NextPC <= MuxOut + INCR (wraps modulo 2^WIDTH).
  - Latency 1 cycle from the PC/Immed/Branch/Zero inputs.
- Reset:
  - While Reset=1 at a rising edge: NextPC <= 0 and NextValid <= 0. This overrides any simultaneous branch.
  - Reset asserted mid-stream clears on the next edge; the combinational outputs are unaffected by reset.
- NextValid: <= 1 on the first rising edge with Reset=0; stays 1 until the next reset.
- Wrap-around cases:
  - PC = 0xFFFFFFFC with no branch gives NextPC = 0x00000000.
  - PC + ShiftOut overflow wraps silently.
- No handshake and no stall input; the register loads every cycle.

Decomposition:
- Shared package pc_pkg holds WIDTH, SHIFT and INCR (INCR = 32'h4), plus the word_t typedef (logic [WIDTH-1:0]).
- One natural sub-module: mux32_2to1 (inputs a, b, sel; output y), instantiated once for the PC/BranchTarget selection.
- The shifter and adder are inline continuous assignments.

Test Plan:
- Reset=1 for 2 cycles, then 0 -> NextPC=0 and NextValid=0 while in reset; after the first free edge, NextValid=1.
- PC=0x00000100, Immed=0x00000003, Branch=1, Zero=1 -> ShiftOut=0x0000000C, BranchTarget=0x0000010C, MuxOut=0x0000010C, next-edge NextPC=0x00000110.
- PC=0x00000100, Immed=0xFFFFFFFE (-2), Branch=1, Zero=1 -> ShiftOut=0xFFFFFFF8, MuxOut=0x000000F8, NextPC=0x000000FC.
- PC=0x00000200, Immed=0x00000010, all four {Branch,Zero} combos -> only 11 gives MuxOut=0x00000240; other three give 0x00000200 and NextPC=0x00000204.
- PC=0xFFFFFFFC, Branch=0 -> NextPC=0x00000000. PC=0xFFFFFFF0, Immed=0x00000008, branch taken -> MuxOut=0x00000010, NextPC=0x00000014.
- Branch taken with Reset=1 on the same edge -> NextPC=0 and NextValid=0. Immed=0x40000001 -> ShiftOut=0x00000004 (top bits dropped).

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and types for the branch-target PC slice
//
// Purpose: datapath width, immediate shift amount and PC increment used by the
// branch-target slice and its mux, plus the word_t datapath type.
// Ports: none (package).

package pc_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHIFT = 2;
  localparam logic [31:0] INCR  = 32'h4;

  typedef logic [WIDTH-1:0] word_t;

endpackage : pc_pkg

// File: rtl/mux32_2to1.sv
// rtl/mux32_2to1.sv - WIDTH-bit two-input multiplexer
//
// Purpose: selects between two words; sel=0 passes a, sel=1 passes b.
// Ports:
//   a   input  WIDTH  selected when sel=0
//   b   input  WIDTH  selected when sel=1
//   sel input  1      select
//   y   output WIDTH  selected word

module mux32_2to1
  import pc_pkg::*;
#(
  parameter int unsigned W = WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);

  // Only the chosen input reaches y, so X on the unselected side is not seen.
  always_comb begin
    if (sel) begin
      y = b;
    end else begin
      y = a;
    end
  end

endmodule : mux32_2to1

// File: rtl/lshift2_mux32_2to1.sv
// rtl/lshift2_mux32_2to1.sv - branch-target computation, PC select and next-PC register
//
// Purpose: forms the branch target PC + (Immed << SHIFT), selects it over PC when
// Branch & Zero, and registers the selected value plus INCR as the next PC.
// Ports:
//   Clock        input  1      rising-edge clock
//   Reset        input  1      synchronous, active-high reset
//   PC           input  WIDTH  current program counter
//   Immed        input  WIDTH  sign-extended branch offset in words
//   Branch       input  1      branch instruction flag
//   Zero         input  1      ALU zero flag
//   ShiftOut     output WIDTH  Immed << SHIFT
//   BranchTarget output WIDTH  PC + ShiftOut (wraps)
//   BranchSelect output 1      Branch & Zero
//   MuxOut       output WIDTH  BranchSelect ? BranchTarget : PC
//   NextPC       output WIDTH  registered MuxOut + INCR
//   NextValid    output 1      registered, set on first edge out of reset

module lshift2_mux32_2to1
  import pc_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  PC,
  input  logic [WIDTH-1:0]  Immed,
  input  logic              Branch,
  input  logic              Zero,
  output logic [WIDTH-1:0]  ShiftOut,
  output logic [WIDTH-1:0]  BranchTarget,
  output logic              BranchSelect,
  output logic [WIDTH-1:0]  MuxOut,
  output logic [WIDTH-1:0]  NextPC,
  output logic              NextValid
);

  localparam word_t INCR_W = word_t'(INCR);

  // Word offset to byte offset; the top SHIFT bits of Immed fall off the end.
  assign ShiftOut     = {Immed[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
  assign BranchTarget = PC + ShiftOut;
  assign BranchSelect = Branch & Zero;

  mux32_2to1 #(
    .W (WIDTH)
  ) u_pc_mux (
    .a   (PC),
    .b   (BranchTarget),
    .sel (BranchSelect),
    .y   (MuxOut)
  );

  // Reset takes priority over any branch presented on the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      NextPC    <= '0;
      NextValid <= 1'b0;
    end else begin
      NextPC    <= MuxOut + INCR_W;
      NextValid <= 1'b1;
    end
  end

endmodule : lshift2_mux32_2to1

// File: tb/tb_lshift2_mux32_2to1.sv
// tb/tb_lshift2_mux32_2to1.sv - directed self-checking bench for lshift2_mux32_2to1

module tb_lshift2_mux32_2to1;

  logic        Clock;
  logic        Reset;
  logic [31:0] PC;
  logic [31:0] Immed;
  logic        Branch;
  logic        Zero;
  logic [31:0] ShiftOut;
  logic [31:0] BranchTarget;
  logic        BranchSelect;
  logic [31:0] MuxOut;
  logic [31:0] NextPC;
  logic        NextValid;

  int checks   = 0;
  int failures = 0;

  lshift2_mux32_2to1 dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .PC           (PC),
    .Immed        (Immed),
    .Branch       (Branch),
    .Zero         (Zero),
    .ShiftOut     (ShiftOut),
    .BranchTarget (BranchTarget),
    .BranchSelect (BranchSelect),
    .MuxOut       (MuxOut),
    .NextPC       (NextPC),
    .NextValid    (NextValid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after an edge, then let the combinational outputs settle.
  task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                       input logic br, input logic z);
    PC     = pc;
    Immed  = imm;
    Branch = br;
    Zero   = z;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);

    // Reset for two edges
    tick();
    tick();
    check("rst_nextpc", NextPC, 32'h0);
    check("rst_valid", {31'b0, NextValid}, 32'h0);

    // First free edge: PC=0, no branch
    Reset = 1'b0;
    tick();
    check("first_valid", {31'b0, NextValid}, 32'h1);
    check("first_nextpc", NextPC, 32'h4);

    // Forward branch taken
    drive(32'h0000_0100, 32'h0000_0003, 1'b1, 1'b1);
    check("fwd_shift", ShiftOut, 32'h0000_000C);
    check("fwd_target", BranchTarget, 32'h0000_010C);
    check("fwd_sel", {31'b0, BranchSelect}, 32'h1);
    check("fwd_mux", MuxOut, 32'h0000_010C);
    tick();
    check("fwd_nextpc", NextPC, 32'h0000_0110);

    // Backward branch taken (Immed = -2)
    drive(32'h0000_0100, 32'hFFFF_FFFE, 1'b1, 1'b1);
    check("bwd_shift", ShiftOut, 32'hFFFF_FFF8);
    check("bwd_mux", MuxOut, 32'h0000_00F8);
    tick();
    check("bwd_nextpc", NextPC, 32'h0000_00FC);

    // All four {Branch,Zero} combinations
    drive(32'h0000_0200, 32'h0000_0010, 1'b0, 1'b0);
    check("bz00_sel", {31'b0, BranchSelect}, 32'h0);
    check("bz00_mux", MuxOut, 32'h0000_0200);
    tick();
    check("bz00_nextpc", NextPC, 32'h0000_0204);

    drive(32'h0000_0200, 32'h0000_0010, 1'b0, 1'b1);
    check("bz01_sel", {31'b0, BranchSelect}, 32'h0);
    check("bz01_mux", MuxOut, 32'h0000_0200);
    tick();
    check("bz01_nextpc", NextPC, 32'h0000_0204);

    drive(32'h0000_0200, 32'h0000_0010, 1'b1, 1'b0);
    check("bz10_sel", {31'b0, BranchSelect}, 32'h0);
    check("bz10_mux", MuxOut, 32'h0000_0200);
    tick();
    check("bz10_nextpc", NextPC, 32'h0000_0204);

    drive(32'h0000_0200, 32'h0000_0010, 1'b1, 1'b1);
    check("bz11_sel", {31'b0, BranchSelect}, 32'h1);
    check("bz11_target", BranchTarget, 32'h0000_0240);
    check("bz11_mux", MuxOut, 32'h0000_0240);
    tick();
    check("bz11_nextpc", NextPC, 32'h0000_0244);

    // Increment wraps past the top of the address space
    drive(32'hFFFF_FFFC, 32'h0000_0010, 1'b0, 1'b1);
    check("wrap_mux", MuxOut, 32'hFFFF_FFFC);
    tick();
    check("wrap_nextpc", NextPC, 32'h0000_0000);

    // Branch target add wraps
    drive(32'hFFFF_FFF0, 32'h0000_0008, 1'b1, 1'b1);
    check("addwrap_target", BranchTarget, 32'h0000_0010);
    check("addwrap_mux", MuxOut, 32'h0000_0010);
    tick();
    check("addwrap_nextpc", NextPC, 32'h0000_0014);

    // Reset on the same edge as a taken branch; combinational path unaffected
    drive(32'h0000_0100, 32'h0000_0003, 1'b1, 1'b1);
    Reset = 1'b1;
    #1;
    check("rstbr_mux", MuxOut, 32'h0000_010C);
    tick();
    check("rstbr_nextpc", NextPC, 32'h0);
    check("rstbr_valid", {31'b0, NextValid}, 32'h0);
    check("rstbr_mux_held", MuxOut, 32'h0000_010C);

    // Top bits of Immed are dropped by the shift
    Reset = 1'b0;
    drive(32'h0000_0100, 32'h4000_0001, 1'b1, 1'b1);
    check("drop_shift", ShiftOut, 32'h0000_0004);
    check("drop_mux", MuxOut, 32'h0000_0104);
    tick();
    check("drop_valid", {31'b0, NextValid}, 32'h1);
    check("drop_nextpc", NextPC, 32'h0000_0108);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lshift2_mux32_2to1
